// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with a ready/valid output.
// Sticky overflow and framing-error flags are cleared by i_clear_err.
module uart_rx_stream #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_rx,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  output logic                          o_frame_err,
  input  logic                          i_clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0]   HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]   FULL_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_cnt, bit_d;
  logic [7:0]  shift, shift_d;
  logic        push, frame_set;
  logic        rx_meta, rx_sync, rx_prev;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          pop, full, push_ok, ovf_set;

  // Synchronizer plus one extra flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_d;
  end

  // Every sample point reloads the baud counter, so each bit period starts fresh
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_d     = bit_cnt;
    shift_d   = shift;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_d = '0;
          if (!rx_sync) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_cnt + 3'd1;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync) push = 1'b1;
          else         frame_set = 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: a pop frees the slot for a same-cycle push even when full
  assign full    = (level == FULL_LVL);
  assign pop     = (level != '0) && i_ready;
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_overflow  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (ovf_set)          o_overflow <= 1'b1;
      else if (i_clear_err) o_overflow <= 1'b0;
      if (frame_set)        o_frame_err <= 1'b1;
      else if (i_clear_err) o_frame_err <= 1'b0;
    end
  end

  assign o_data  = mem[rd_ptr];
  assign o_valid = (level != '0);
  assign o_level = level;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at 16 clocks per bit and an 8-deep FIFO.
module tb_uart_rx_stream;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_level;
  logic       o_overflow;
  logic       o_frame_err;
  logic       i_clear_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] popq [$];
  int         popt [$];

  uart_rx_stream #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_level(o_level), .o_overflow(o_overflow),
    .o_frame_err(o_frame_err), .i_clear_err(i_clear_err)
  );

  always #5 clk = ~clk;

  // Record every accepted byte with the cycle it was taken
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && o_valid && i_ready) begin
      popq.push_back(o_data);
      popt.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rdy;
    int         pops;
    int         lvl;
    logic       ferr;
    logic       ovf;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      wait_cyc(CPB);
    end
    i_rx = stop;
    wait_cyc(CPB);
    i_rx = 1'b1;
    wait_cyc(20);
  endtask

  task automatic pop_at(input int idx, output logic [31:0] v);
    v = (popq.size() > idx) ? {24'd0, popq[idx]} : 32'hDEAD_BEEF;
  endtask

  logic [31:0] got;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b1, 1, 0, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 1, 0, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 0, 1, 1'b1, 1'b0};

    rst_n = 1'b0; i_rx = 1'b1; i_ready = 1'b0; i_clear_err = 1'b0;
    wait_cyc(4);
    chk("reset_valid", o_valid, 0);
    chk("reset_level", o_level, 0);
    chk("reset_ovf", o_overflow, 0);
    chk("reset_ferr", o_frame_err, 0);
    rst_n = 1'b1;
    wait_cyc(5);

    for (int k = 0; k < 5; k++) begin
      popq.delete(); popt.delete();
      i_ready = tbl[k].rdy;
      send_byte(tbl[k].data, tbl[k].stop);
      chk($sformatf("v%0d_pops", k), popq.size(), tbl[k].pops);
      if (tbl[k].pops > 0) begin
        pop_at(0, got);
        chk($sformatf("v%0d_byte", k), got, {24'd0, tbl[k].data});
      end
      chk($sformatf("v%0d_level", k), o_level, tbl[k].lvl);
      chk($sformatf("v%0d_ferr", k), o_frame_err, tbl[k].ferr);
      chk($sformatf("v%0d_ovf", k), o_overflow, tbl[k].ovf);
    end

    // Drain the held 0xFF and clear the framing error
    popq.delete();
    chk("ff_data", o_data, 8'hFF);
    i_ready = 1'b1; wait_cyc(3);
    pop_at(0, got);
    chk("ff_pop", got, 8'hFF);
    chk("ff_pops", popq.size(), 1);
    i_clear_err = 1'b1; wait_cyc(1); i_clear_err = 1'b0; wait_cyc(1);
    chk("ferr_cleared", o_frame_err, 0);

    // Three bytes held, then released on consecutive cycles
    i_ready = 1'b0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h7F, 1'b1);
    chk("hold3_level", o_level, 3);
    chk("hold3_valid", o_valid, 1);
    chk("hold3_head", o_data, 8'h01);
    popq.delete(); popt.delete();
    i_ready = 1'b1; wait_cyc(5); i_ready = 1'b0;
    pop_at(0, got); chk("hold3_b0", got, 8'h01);
    pop_at(1, got); chk("hold3_b1", got, 8'h04);
    pop_at(2, got); chk("hold3_b2", got, 8'h7F);
    chk("hold3_pops", popq.size(), 3);
    if (popt.size() == 3) begin
      chk("hold3_consec1", popt[1] - popt[0], 1);
      chk("hold3_consec2", popt[2] - popt[1], 1);
    end
    chk("hold3_level_end", o_level, 0);

    // Nine bytes into an 8-deep FIFO: last one dropped
    for (int b = 0; b < 9; b++) send_byte(8'(b), 1'b1);
    chk("ovf_level", o_level, 8);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_head", o_data, 8'h00);
    popq.delete();
    i_ready = 1'b1; wait_cyc(12); i_ready = 1'b0;
    chk("ovf_pops", popq.size(), 8);
    for (int b = 0; b < 8; b++) begin
      pop_at(b, got);
      chk($sformatf("ovf_b%0d", b), got, 32'(b));
    end
    chk("ovf_level_end", o_level, 0);
    chk("ovf_sticky", o_overflow, 1);
    i_clear_err = 1'b1; wait_cyc(1); i_clear_err = 1'b0; wait_cyc(1);
    chk("ovf_cleared", o_overflow, 0);

    // Short low glitch on the idle line
    popq.delete();
    i_ready = 1'b1;
    i_rx = 1'b0; wait_cyc(6); i_rx = 1'b1;
    wait_cyc(200);
    chk("glitch_pops", popq.size(), 0);
    chk("glitch_level", o_level, 0);
    chk("glitch_ferr", o_frame_err, 0);
    chk("glitch_ovf", o_overflow, 0);

    // Reset during data bit 4 of 0xFF, then a clean 0x12
    i_ready = 1'b0;
    popq.delete();
    i_rx = 1'b0; wait_cyc(CPB);
    i_rx = 1'b1; wait_cyc(4 * CPB + CPB / 2);
    rst_n = 1'b0; wait_cyc(2); rst_n = 1'b1;
    wait_cyc(5 * CPB + 20);
    chk("rst_level_mid", o_level, 0);
    send_byte(8'h12, 1'b1);
    chk("rst_level", o_level, 1);
    chk("rst_head", o_data, 8'h12);
    i_ready = 1'b1; wait_cyc(3);
    chk("rst_pops", popq.size(), 1);
    pop_at(0, got); chk("rst_byte", got, 8'h12);
    chk("rst_ferr", o_frame_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
